// File: rtl/frame_capture.sv
// -----------------------------------------------------------------------------
// frame_capture
//
// Captures one camera frame (RGB565 byte stream, high byte first) into a frame
// RAM, then holds it for a reader until that reader acknowledges it.
//
// Flow: IDLE -> WAIT_FRAME -> (vsync falls) -> CAPTURE -> (limit reached) ->
// READY -> (frame_ack) -> WAIT_FRAME. A vsync rise during CAPTURE before the
// limit aborts the frame with a one-cycle o_error pulse. Dropping i_enable
// returns to IDLE from any state.
//
// Optional feature macro: CAPTURE_DECIMATE_EN
//   When defined, every second pixel of a line (both of its bytes) is dropped,
//   giving 2:1 horizontal decimation. A per-line pixel counter restarts on
//   each i_href rising edge. When undefined, every href byte is written.
//
// Ports
//   i_clk            clock, all registers on the rising edge
//   i_reset          asynchronous active-high reset
//   i_enable         capture enable; low forces IDLE
//   i_vsync          camera frame sync, high = vertical blanking
//   i_href           camera line valid, one byte per cycle while high
//   i_pixel_data     camera byte
//   i_BytesPerFrame  number of RAM bytes per frame, latched at frame start
//   i_frame_ack      reader releases the held frame
//   o_RAM_adress     RAM write address (holds its last value between writes)
//   o_RAM_data       RAM write data    (holds its last value between writes)
//   o_RAM_we         RAM write strobe, exactly one cycle after the href byte
//   o_done           a complete frame is held in RAM
//   o_error          one-cycle pulse when a frame is cut short by vsync
//
// Handshake: the camera side has no back-pressure. A byte is offered in every
// cycle with i_href=1 and is either written (o_RAM_we=1 on the next cycle) or
// dropped; o_done stays high until i_frame_ack=1 is seen in READY.
//
// The FSM state is held in the signal 'state' (type state_t) so checkers can
// observe it directly.
// -----------------------------------------------------------------------------
module frame_capture (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic [7:0]  i_pixel_data,
    input  logic [14:0] i_BytesPerFrame,
    input  logic        i_frame_ack,
    output logic [14:0] o_RAM_adress,
    output logic [7:0]  o_RAM_data,
    output logic        o_RAM_we,
    output logic        o_done,
    output logic        o_error
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2,
        READY      = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        vsync_q;
    logic        vsync_fall;
    logic        vsync_rise;

    logic [14:0] byte_cnt;
    logic [14:0] limit;
    logic [14:0] cnt_inc;

    logic        byte_keep;
    logic        accept;
    logic        limit_hit;
    logic        do_write;
    logic        frame_start;
    logic        abort;

    // Edges are taken against the registered copy of vsync.
    assign vsync_fall = vsync_q & ~i_vsync;
    assign vsync_rise = ~vsync_q & i_vsync;

`ifdef CAPTURE_DECIMATE_EN
    // Per-line byte/pixel tracking. The byte seen on an href rising edge is
    // byte 0 of pixel 0, so the "current" phase and pixel are overridden on
    // that cycle instead of waiting for the registers to clear.
    logic        href_q;
    logic        href_rise;
    logic        byte_phase;
    logic [10:0] pix_cnt;
    logic        cur_phase;
    logic [10:0] cur_pix;

    assign href_rise = i_href & ~href_q;
    assign cur_phase = href_rise ? 1'b0 : byte_phase;
    assign cur_pix   = href_rise ? 11'd0 : pix_cnt;
    // Even pixels (both bytes) are kept.
    assign byte_keep = ~cur_pix[0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            href_q     <= 1'b0;
            byte_phase <= 1'b0;
            pix_cnt    <= 11'd0;
        end else begin
            href_q <= i_href;
            if (i_href) begin
                byte_phase <= ~cur_phase;
                // Only the parity is used; wrapping on very long lines is
                // harmless.
                pix_cnt    <= cur_phase ? (cur_pix + 11'd1) : cur_pix;
            end
        end
    end
`else
    assign byte_keep = 1'b1;
`endif

    assign cnt_inc = byte_cnt + 15'd1;

    // A byte is written only while the frame still has room, so the counter
    // stops exactly at the limit and can never wrap.
    assign accept = (state == CAPTURE) & i_href & byte_keep & (byte_cnt != limit);

    // Completion is recognised in the same cycle as the final write, so the
    // final write and o_done appear together. It also covers a limit of 0
    // (counter already equal to the limit on the first CAPTURE cycle).
    assign limit_hit = (byte_cnt == limit) | (accept & (cnt_inc == limit));

    assign do_write = accept & i_enable;

    // Next-state logic
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        abort       = 1'b0;
        if (!i_enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (vsync_fall) begin
                        state_next  = CAPTURE;
                        frame_start = 1'b1;
                    end
                end
                CAPTURE: begin
                    // Completion takes priority over a coincident vsync rise.
                    if (limit_hit) begin
                        state_next = READY;
                    end else if (vsync_rise) begin
                        state_next = WAIT_FRAME;
                        abort      = 1'b1;
                    end
                end
                READY: begin
                    if (i_frame_ack) begin
                        state_next = WAIT_FRAME;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register and vsync history
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            vsync_q <= 1'b0;
        end else begin
            state   <= state_next;
            vsync_q <= i_vsync;
        end
    end

    // Frame limit and byte counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            limit    <= 15'd0;
            byte_cnt <= 15'd0;
        end else begin
            if (frame_start) begin
                limit    <= i_BytesPerFrame;
                byte_cnt <= 15'd0;
            end else if (do_write) begin
                byte_cnt <= cnt_inc;
            end
        end
    end

    // Registered RAM port and status outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_RAM_adress <= 15'd0;
            o_RAM_data   <= 8'd0;
            o_RAM_we     <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_RAM_we <= do_write;
            if (do_write) begin
                o_RAM_adress <= byte_cnt;
                o_RAM_data   <= i_pixel_data;
            end
            // o_done tracks READY; it drops with ack or with enable low.
            o_done  <= (state_next == READY);
            o_error <= abort;
        end
    end

endmodule

// File: tb/tb_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_frame_capture
//
// Table-driven bench for frame_capture. Each record holds the inputs for one
// clock cycle and the outputs expected just after that cycle's rising edge.
// Records are generated by small helper tasks that track the expected RAM
// address/data/done of the reference behaviour; reset cases are hand-written.
// Works with and without CAPTURE_DECIMATE_EN.
// -----------------------------------------------------------------------------
module tb_frame_capture;

    logic        i_clk;
    logic        i_reset;
    logic        i_enable;
    logic        i_vsync;
    logic        i_href;
    logic [7:0]  i_pixel_data;
    logic [14:0] i_BytesPerFrame;
    logic        i_frame_ack;
    logic [14:0] o_RAM_adress;
    logic [7:0]  o_RAM_data;
    logic        o_RAM_we;
    logic        o_done;
    logic        o_error;

    int total;
    int bad;

    frame_capture dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_vsync         (i_vsync),
        .i_href          (i_href),
        .i_pixel_data    (i_pixel_data),
        .i_BytesPerFrame (i_BytesPerFrame),
        .i_frame_ack     (i_frame_ack),
        .o_RAM_adress    (o_RAM_adress),
        .o_RAM_data      (o_RAM_data),
        .o_RAM_we        (o_RAM_we),
        .o_done          (o_done),
        .o_error         (o_error)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        en;
        logic        vs;
        logic        hr;
        logic [7:0]  d;
        logic        ack;
        logic [14:0] lim;
        logic        we;
        logic [14:0] addr;
        logic [7:0]  data;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    // Expected-behaviour tracking used while building the table
    int          m_cnt;
    int          m_lim;
    logic [14:0] m_addr;
    logic [7:0]  m_data;
    logic        m_done;
    logic [14:0] cur_lim;

    function automatic logic keep_byte(input int idx);
`ifdef CAPTURE_DECIMATE_EN
        return ((idx / 2) % 2) == 0;
`else
        return (idx >= 0);
`endif
    endfunction

    task automatic push(input logic en, input logic vs, input logic hr,
                        input logic [7:0] d, input logic ack,
                        input logic we, input logic err);
        vec_t v;
        v.en   = en;
        v.vs   = vs;
        v.hr   = hr;
        v.d    = d;
        v.ack  = ack;
        v.lim  = cur_lim;
        v.we   = we;
        v.addr = m_addr;
        v.data = m_data;
        v.done = m_done;
        v.err  = err;
        vecs.push_back(v);
    endtask

    // A cycle with no write expected.
    task automatic cyc(input logic en, input logic vs, input logic hr,
                       input logic [7:0] d, input logic err);
        if (!en) m_done = 1'b0;
        push(en, vs, hr, d, 1'b0, 1'b0, err);
    endtask

    // vsync falling cycle (vsync must have been high the cycle before).
    task automatic frame_start(input logic [14:0] lim);
        cur_lim = lim;
        m_lim   = int'(lim);
        m_cnt   = 0;
        push(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // One href line of n bytes starting at value base; vs_last is the vsync
    // level during the final byte.
    task automatic burst(input int n, input logic [7:0] base, input logic vs_last);
        logic wr;
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b  = base + 8'(i);
            wr = keep_byte(i) && (m_cnt < m_lim);
            if (wr) begin
                m_addr = 15'(m_cnt);
                m_data = b;
                m_cnt++;
            end
            if (m_cnt == m_lim) m_done = 1'b1;
            push(1'b1, (i == n - 1) ? vs_last : 1'b0, 1'b1, b, 1'b0, wr, 1'b0);
        end
    endtask

    task automatic ack_cyc(input logic vs);
        m_done = 1'b0;
        push(1'b1, vs, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic we,
                             input logic [14:0] addr, input logic [7:0] data,
                             input logic done, input logic err);
        check({tag, ".we"},   idx, 32'(o_RAM_we),     32'(we));
        check({tag, ".addr"}, idx, 32'(o_RAM_adress), 32'(addr));
        check({tag, ".data"}, idx, 32'(o_RAM_data),   32'(data));
        check({tag, ".done"}, idx, 32'(o_done),       32'(done));
        check({tag, ".err"},  idx, 32'(o_error),      32'(err));
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            i_enable        = vecs[i].en;
            i_vsync         = vecs[i].vs;
            i_href          = vecs[i].hr;
            i_pixel_data    = vecs[i].d;
            i_frame_ack     = vecs[i].ack;
            i_BytesPerFrame = vecs[i].lim;
            @(posedge i_clk);
            #1;
            check_all(tag, i, vecs[i].we, vecs[i].addr, vecs[i].data,
                      vecs[i].done, vecs[i].err);
        end
        vecs.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        int lim_a;
        int n_restart;
`ifdef CAPTURE_DECIMATE_EN
        lim_a     = 4;   // 8 bytes decimate to 4 written
        n_restart = 10;  // keeps bytes 0,1,4,5,8 -> 5 written
`else
        lim_a     = 8;
        n_restart = 7;   // 5 written, 2 ignored after completion
`endif
        total = 0;
        bad   = 0;
        m_cnt = 0; m_lim = 0; m_addr = 15'd0; m_data = 8'd0; m_done = 1'b0;
        cur_lim = 15'd0;

        i_reset         = 1'b1;
        i_enable        = 1'b0;
        i_vsync         = 1'b0;
        i_href          = 1'b0;
        i_pixel_data    = 8'h00;
        i_BytesPerFrame = 15'd0;
        i_frame_ack     = 1'b0;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check_all("reset", 0, 1'b0, 15'd0, 8'd0, 1'b0, 1'b0);
        i_reset = 1'b0;

        // Frame of 0x10..0x17, writes 1 cycle after each byte, then done
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        frame_start(15'(lim_a));
        burst(8, 8'h10, 1'b0);

        // Held in READY: a second frame streams with no ack -> no writes
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b1, 8'h20 + 8'(i), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        ack_cyc(1'b0);
        // Waiting for the next vsync fall: href bytes are not written
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 8'h28 + 8'(i), 1'b0);

        // Limit 10, vsync rises after 6 bytes -> one-cycle error pulse
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        frame_start(15'd10);
        burst(6, 8'h30, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Restart at address 0 with an odd limit of 5; excess bytes ignored
        frame_start(15'd5);
        burst(n_restart, 8'h40, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        ack_cyc(1'b0);

        // Limit 0: done the cycle after the frame start, no write
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        frame_start(15'd0);
        burst(1, 8'h55, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        ack_cyc(1'b0);

        // Final byte coincides with vsync rise: completion wins, no error
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        frame_start(15'd2);
        burst(2, 8'h60, 1'b1);
        ack_cyc(1'b1);

        // Enable drop during CAPTURE: no write, address holds
        frame_start(15'd4);
        burst(1, 8'h70, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h71, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Enable drop in READY clears done
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        frame_start(15'd1);
        burst(1, 8'h80, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Start of a frame to be interrupted by reset
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        frame_start(15'd8);
        burst(3, 8'h90, 1'b0);
        run_vecs("main");

        // Reset asserted during byte 3: outputs clear without a clock edge
        i_href       = 1'b1;
        i_pixel_data = 8'h93;
        #2;
        i_reset = 1'b1;
        #1;
        check_all("async_rst", 0, 1'b0, 15'd0, 8'd0, 1'b0, 1'b0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        m_addr = 15'd0; m_data = 8'd0; m_done = 1'b0;

        // After release, nothing is written until the next vsync fall
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 8'hB0 + 8'(i), 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        frame_start(15'd2);
        burst(2, 8'hA0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        run_vecs("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
